// File: rtl/dragon_pkg.sv
// Constants shared by the dragon head and dragon body blocks: cell and
// heading widths, heading encodings and the off-board parking position.
package dragon_pkg;

  localparam int POS_W = 8;
  localparam int DIR_W = 2;

  typedef enum logic [DIR_W-1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  // Parking cell the head reloads to; the body history starts filled with it.
  localparam logic [POS_W-1:0] DRAGON_RESET_POS = 8'hFB;
  localparam logic [DIR_W-1:0] DRAGON_RESET_DIR = DIR_LEFT;

endpackage

// File: rtl/dragon_segment_hit.sv
// Combinational player-versus-body test: one comparator per history slot,
// masked to the visible length and OR-reduced.
module dragon_segment_hit
  import dragon_pkg::*;
#(
  parameter int MAX_SEGMENTS = 8,
  parameter int IDX_W        = $clog2(MAX_SEGMENTS)
) (
  input  logic [POS_W-1:0] seg_pos [MAX_SEGMENTS],
  input  logic [IDX_W:0]   length,
  input  logic [POS_W-1:0] player_pos,
  output logic             hit
);

  logic [MAX_SEGMENTS-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < MAX_SEGMENTS; i++) begin
      match[i] = ((IDX_W+1)'(i) < length) && (seg_pos[i] == player_pos);
    end
  end

  assign hit = |match;

endmodule

// File: rtl/dragon_body.sv
// Trailing body of the dragon: shifts the cell vacated by the head into a
// fixed-depth history, serves a registered read port and flags body hits.
module dragon_body
  import dragon_pkg::*;
#(
  parameter int MAX_SEGMENTS = 8,
  parameter int INIT_LENGTH  = 2,
  parameter int MIN_LENGTH   = 1,
  parameter int IDX_W        = $clog2(MAX_SEGMENTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [POS_W-1:0] head_pos,
  input  logic [DIR_W-1:0] head_direction,
  input  logic             grow,
  input  logic             shrink,
  input  logic [POS_W-1:0] player_pos,
  input  logic [IDX_W-1:0] rd_index,
  output logic [POS_W-1:0] rd_pos,
  output logic [DIR_W-1:0] rd_dir,
  output logic             rd_valid,
  output logic [IDX_W:0]   length,
  output logic             body_hit,
  output logic             moved
);

  localparam logic [IDX_W:0] LEN_MAX  = (IDX_W+1)'(MAX_SEGMENTS);
  localparam logic [IDX_W:0] LEN_MIN  = (IDX_W+1)'(MIN_LENGTH);
  localparam logic [IDX_W:0] LEN_INIT = (IDX_W+1)'(INIT_LENGTH);

  logic [POS_W-1:0] prev_head;
  logic [POS_W-1:0] seg_pos [MAX_SEGMENTS];
  logic [DIR_W-1:0] seg_dir [MAX_SEGMENTS];
  logic [IDX_W:0]   length_next;
  logic             shift;
  logic             hit_now;

  // Any change of head cell counts as a move, including multi-cell jumps.
  assign shift = (head_pos != prev_head);

  always_comb begin
    length_next = length;
    if (grow && !shrink) begin
      if (length < LEN_MAX) length_next = length + 1'b1;
    end else if (shrink && !grow) begin
      if (length > LEN_MIN) length_next = length - 1'b1;
    end
  end

  // Every slot shifts regardless of length so growing exposes real history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_head <= DRAGON_RESET_POS;
      for (int i = 0; i < MAX_SEGMENTS; i++) begin
        seg_pos[i] <= DRAGON_RESET_POS;
        seg_dir[i] <= DRAGON_RESET_DIR;
      end
    end else if (shift) begin
      prev_head  <= head_pos;
      seg_pos[0] <= prev_head;
      seg_dir[0] <= head_direction;
      for (int i = 1; i < MAX_SEGMENTS; i++) begin
        seg_pos[i] <= seg_pos[i-1];
        seg_dir[i] <= seg_dir[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      length <= LEN_INIT;
      moved  <= 1'b0;
    end else begin
      length <= length_next;
      moved  <= shift;
    end
  end

  dragon_segment_hit #(
    .MAX_SEGMENTS (MAX_SEGMENTS),
    .IDX_W        (IDX_W)
  ) u_segment_hit (
    .seg_pos    (seg_pos),
    .length     (length),
    .player_pos (player_pos),
    .hit        (hit_now)
  );

  // Read port and hit flag both sample the state as it was before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pos   <= '0;
      rd_dir   <= '0;
      rd_valid <= 1'b0;
      body_hit <= 1'b0;
    end else begin
      rd_pos   <= seg_pos[rd_index];
      rd_dir   <= seg_dir[rd_index];
      rd_valid <= ({1'b0, rd_index} < length);
      body_hit <= hit_now;
    end
  end

endmodule

// File: tb/tb_dragon_body.sv
// Bench for dragon_body: hand-derived vector table, corner-case sequences
// and a reference-model scoreboard under random stimulus.
module tb_dragon_body;

  localparam int W = 17;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] head_pos;
  logic [1:0] head_direction;
  logic       grow;
  logic       shrink;
  logic [7:0] player_pos;
  logic [2:0] rd_index;
  logic [7:0] rd_pos;
  logic [1:0] rd_dir;
  logic       rd_valid;
  logic [3:0] length;
  logic       body_hit;
  logic       moved;

  int checks = 0;
  int passed = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [7:0] head;
    logic [1:0] dir;
    logic       g;
    logic       s;
    logic [7:0] player;
    logic [2:0] idx;
    logic       e_moved;
    logic [3:0] e_len;
    logic       e_valid;
    logic [7:0] e_pos;
    logic [1:0] e_dir;
    logic       e_hit;
  } vec_t;

  vec_t tbl[$];

  logic [7:0] m_seg [8];
  logic [1:0] m_dir [8];
  logic [7:0] m_prev;
  int         m_len;

  always #5 clk = ~clk;

  dragon_body dut (
    .clk            (clk),
    .reset          (reset),
    .head_pos       (head_pos),
    .head_direction (head_direction),
    .grow           (grow),
    .shrink         (shrink),
    .player_pos     (player_pos),
    .rd_index       (rd_index),
    .rd_pos         (rd_pos),
    .rd_dir         (rd_dir),
    .rd_valid       (rd_valid),
    .length         (length),
    .body_hit       (body_hit),
    .moved          (moved)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [7:0] h, input logic [1:0] d, input logic g,
                              input logic s, input logic [7:0] p, input logic [2:0] idx,
                              input logic em, input logic [3:0] el, input logic ev,
                              input logic [7:0] ep, input logic [1:0] ed, input logic eh);
    vec_t v;
    v.head = h; v.dir = d; v.g = g; v.s = s; v.player = p; v.idx = idx;
    v.e_moved = em; v.e_len = el; v.e_valid = ev; v.e_pos = ep; v.e_dir = ed; v.e_hit = eh;
    return v;
  endfunction

  function automatic logic [W-1:0] pack_exp(input logic m, input logic [3:0] l, input logic v,
                                            input logic [7:0] p, input logic [1:0] d,
                                            input logic h);
    return {m, l, v, p, d, h};
  endfunction

  task automatic drive(input logic [7:0] h, input logic [1:0] d, input logic g,
                       input logic s, input logic [7:0] p, input logic [2:0] idx);
    head_pos = h; head_direction = d; grow = g; shrink = s; player_pos = p; rd_index = idx;
  endtask

  task automatic edge_and_score(input string tag);
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL %s.queue: got empty scoreboard, want one entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".moved"}, moved, e[16]);
      chk({tag, ".length"}, length, e[15:12]);
      chk({tag, ".rd_valid"}, rd_valid, e[11]);
      chk({tag, ".rd_pos"}, rd_pos, e[10:3]);
      chk({tag, ".rd_dir"}, rd_dir, e[2:1]);
      chk({tag, ".body_hit"}, body_hit, e[0]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".rd_pos"}, rd_pos, 8'h00);
    chk({tag, ".rd_dir"}, rd_dir, 2'b00);
    chk({tag, ".rd_valid"}, rd_valid, 1'b0);
    chk({tag, ".body_hit"}, body_hit, 1'b0);
    chk({tag, ".moved"}, moved, 1'b0);
    chk({tag, ".length"}, length, 4'd2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] h;
    logic [1:0] d;
    logic [7:0] p;
    logic [2:0] idx;
    logic       g;
    logic       s;
    logic       e_moved;
    logic       e_hit;
    logic       e_valid;
    logic [7:0] e_pos;
    logic [1:0] e_dir;

    // Hand-derived vectors; expectations are the registered outputs after the edge.
    tbl.push_back(mk(8'hFB, 2'd3, 0, 0, 8'h00, 3'd0, 0, 4'd2, 1, 8'hFB, 2'd3, 0));
    tbl.push_back(mk(8'hFB, 2'd3, 0, 0, 8'h00, 3'd2, 0, 4'd2, 0, 8'hFB, 2'd3, 0));
    tbl.push_back(mk(8'hEB, 2'd3, 0, 0, 8'h00, 3'd0, 1, 4'd2, 1, 8'hFB, 2'd3, 0));
    tbl.push_back(mk(8'hEB, 2'd3, 0, 0, 8'h00, 3'd0, 0, 4'd2, 1, 8'hFB, 2'd3, 0));
    tbl.push_back(mk(8'hDB, 2'd3, 0, 0, 8'h00, 3'd0, 1, 4'd2, 1, 8'hFB, 2'd3, 0));
    tbl.push_back(mk(8'hDB, 2'd3, 0, 0, 8'h00, 3'd0, 0, 4'd2, 1, 8'hEB, 2'd3, 0));
    tbl.push_back(mk(8'hDB, 2'd3, 0, 0, 8'h00, 3'd1, 0, 4'd2, 1, 8'hFB, 2'd3, 0));
    tbl.push_back(mk(8'hDB, 2'd3, 0, 0, 8'hFB, 3'd0, 0, 4'd2, 1, 8'hEB, 2'd3, 1));
    tbl.push_back(mk(8'hDB, 2'd3, 0, 1, 8'hFB, 3'd0, 0, 4'd1, 1, 8'hEB, 2'd3, 1));
    tbl.push_back(mk(8'hDB, 2'd3, 0, 0, 8'hFB, 3'd0, 0, 4'd1, 1, 8'hEB, 2'd3, 0));
    tbl.push_back(mk(8'hDB, 2'd3, 0, 0, 8'h00, 3'd1, 0, 4'd1, 0, 8'hFB, 2'd3, 0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(8'hDB, 2'd3, 1, 0, 8'h00, 3'd0, 0, 4'((k + 1 > 8) ? 8 : k + 1),
                       1, 8'hEB, 2'd3, 0));
    tbl.push_back(mk(8'hDB, 2'd3, 0, 0, 8'h00, 3'd7, 0, 4'd8, 1, 8'hFB, 2'd3, 0));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(8'hDB, 2'd3, 0, 1, 8'h00, 3'd0, 0, 4'((8 - k < 1) ? 1 : 8 - k),
                       1, 8'hEB, 2'd3, 0));
    tbl.push_back(mk(8'hDB, 2'd3, 1, 1, 8'h00, 3'd0, 0, 4'd1, 1, 8'hEB, 2'd3, 0));
    tbl.push_back(mk(8'hDB, 2'd3, 1, 0, 8'h00, 3'd0, 0, 4'd2, 1, 8'hEB, 2'd3, 0));
    tbl.push_back(mk(8'hDC, 2'd1, 0, 0, 8'h00, 3'd0, 1, 4'd2, 1, 8'hEB, 2'd3, 0));
    tbl.push_back(mk(8'hDC, 2'd1, 0, 0, 8'h00, 3'd0, 0, 4'd2, 1, 8'hDB, 2'd1, 0));
    tbl.push_back(mk(8'hDC, 2'd1, 0, 0, 8'h00, 3'd1, 0, 4'd2, 1, 8'hEB, 2'd3, 0));

    // Clock/reset
    reset = 1'b0;
    drive(8'hFB, 2'd3, 0, 0, 8'h00, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].head, tbl[i].dir, tbl[i].g, tbl[i].s, tbl[i].player, tbl[i].idx);
      exp_q.push_back(pack_exp(tbl[i].e_moved, tbl[i].e_len, tbl[i].e_valid,
                               tbl[i].e_pos, tbl[i].e_dir, tbl[i].e_hit));
      edge_and_score($sformatf("vec%0d", i));
    end

    // Ten consecutive moves, then grow: the new tail is real trail history.
    for (int k = 1; k <= 10; k++) begin
      drive(8'h10 + 8'(k), 2'(k), 0, 0, 8'h00, 3'd0);
      @(posedge clk);
      #1;
      chk($sformatf("trail.move%0d", k), moved, 1'b1);
    end
    drive(8'h1A, 2'd2, 1, 0, 8'h00, 3'd0);
    @(posedge clk);
    #1;
    chk("trail.grow_len", length, 4'd3);
    chk("trail.grow_moved", moved, 1'b0);
    drive(8'h1A, 2'd2, 0, 0, 8'h00, 3'd2);
    @(posedge clk);
    #1;
    chk("trail.tail_pos", rd_pos, 8'h17);
    chk("trail.tail_dir", rd_dir, 2'd0);
    chk("trail.tail_valid", rd_valid, 1'b1);
    drive(8'h1A, 2'd2, 0, 0, 8'h00, 3'd5);
    @(posedge clk);
    #1;
    chk("trail.hidden_pos", rd_pos, 8'h14);
    chk("trail.hidden_dir", rd_dir, 2'd1);
    chk("trail.hidden_valid", rd_valid, 1'b0);

    // Reset asserted mid-operation, right after a moved pulse.
    drive(8'h20, 2'd2, 0, 0, 8'h00, 3'd0);
    @(posedge clk);
    #1;
    chk("midrst.pre_moved", moved, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    drive(8'hFB, 2'd3, 0, 0, 8'h00, 3'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("release.moved", moved, 1'b0);
    chk("release.rd_pos", rd_pos, 8'hFB);
    chk("release.rd_dir", rd_dir, 2'd3);
    chk("release.rd_valid", rd_valid, 1'b1);
    chk("release.length", length, 4'd2);
    @(posedge clk);
    #1;
    chk("release.moved2", moved, 1'b0);

    // Random stimulus against a reference model of the trail.
    m_prev = 8'hFB;
    m_len  = 2;
    for (int i = 0; i < 8; i++) begin
      m_seg[i] = 8'hFB;
      m_dir[i] = 2'd3;
    end
    h = 8'hFB;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 3) h = 8'($urandom_range(0, 255));
      d   = 2'($urandom_range(0, 3));
      g   = ($urandom_range(0, 3) == 0);
      s   = ($urandom_range(0, 3) == 0);
      idx = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) p = m_seg[$urandom_range(0, 7)];
      else p = 8'($urandom_range(0, 255));

      e_moved = (h != m_prev);
      e_valid = (int'(idx) < m_len);
      e_pos   = m_seg[idx];
      e_dir   = m_dir[idx];
      e_hit   = 1'b0;
      for (int i = 0; i < m_len; i++)
        if (m_seg[i] == p) e_hit = 1'b1;
      if (g && !s && m_len < 8) m_len++;
      else if (s && !g && m_len > 1) m_len--;
      if (e_moved) begin
        for (int i = 7; i >= 1; i--) begin
          m_seg[i] = m_seg[i-1];
          m_dir[i] = m_dir[i-1];
        end
        m_seg[0] = m_prev;
        m_dir[0] = d;
        m_prev   = h;
      end

      drive(h, d, g, s, p, idx);
      exp_q.push_back(pack_exp(e_moved, 4'(m_len), e_valid, e_pos, e_dir, e_hit));
      edge_and_score($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
